chunked_add_sequencer: RTL
==========================

# chunked_add_sequencer

Multi-cycle wide adder that computes A+B+CIN for WIDTH-bit operands by stepping one CHUNK-bit carry-lookahead adder across the operands, least-significant chunk first, carrying between cycles through a register. It sits between a valid/ready producer and consumer and trades latency for area: one narrow adder serves an arbitrarily wide add. It owns all sequencing (operand capture, chunk select, carry chaining, result assembly, output hold).

## Interface
- WIDTH, 32: operand width in bits; must be a multiple of CHUNK (elaboration-time assertion).
- CHUNK, 4: width of the shared adder datapath.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a, b  input  WIDTH  operands, sampled on the accept cycle only.
- cin  input  1  carry-in, sampled with a/b.
- out_valid  output  1  result valid (high only in DONE).
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH+1  {carry-out, sum}; held stable while out_valid=1.
- busy  output  1  high in RUN.

## Operation
- NCHUNK = WIDTH/CHUNK; counter width = clog2(NCHUNK), minimum 1.
- States: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE: in_ready=1. On in_valid: capture a, b into operand shift registers, cin into carry register, clear chunk counter, clear result register, go RUN.
- RUN: each cycle, the adder takes the low CHUNK bits of both operand registers plus the carry register. Its CHUNK sum bits are written into result[idx*CHUNK +: CHUNK]; its carry-out replaces the carry register; operand registers shift right by CHUNK; counter increments.
- On the cycle the counter equals NCHUNK-1: write the final chunk, write the carry-out into result[WIDTH], go DONE.
- DONE: out_valid=1. result holds. On out_ready, go IDLE.
- No input pipelining: a new operand is not accepted in the DONE->IDLE transition cycle. The earliest next accept is the cycle after out_ready handshake.
- in_valid during RUN/DONE is ignored (in_ready=0). Producer must hold in_valid/a/b/cin until the handshake.
- Arithmetic is unsigned modulo 2^(WIDTH+1). There is no overflow flag; result[WIDTH] is the carry.
- Asynchronous reset mid-RUN or mid-DONE abandons the operation with no output.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, busy=0, result=0, carry/counter/operand registers=0.
- Accept at edge T0. RUN covers T0+1 .. T0+NCHUNK. out_valid rises after edge T0+NCHUNK.
- Latency from accept to out_valid: NCHUNK cycles (8 at defaults).
- Throughput: one add per NCHUNK+2 cycles with an always-ready consumer.
- out_ready asserted in the same cycle out_valid rises completes the handshake at the next edge. out_ready=0 stalls in DONE indefinitely.
- Outputs in_ready, out_valid and busy are decoded directly from state registers, with no combinational path from inputs.
- Degenerate case CHUNK=WIDTH: NCHUNK=1, single RUN cycle.

## Structure
- Shared package: state enum (IDLE, RUN, DONE) and a clog2-based counter-width helper function.
- One sub-module: the team's existing carry_lookahead_adder, instantiated once with N=CHUNK. Its (CHUNK+1)-bit output is split into sum chunk and carry-out.
- Everything else (FSM, counter, shift registers, result register) lives in chunked_add_sequencer.

## Test plan
- Reset then idle: in_ready=1, out_valid=0, result=0. Assert rst_n low mid-RUN: outputs return to reset values immediately, with no out_valid afterwards.
- a=32'h0000_0001, b=32'h0000_0002, cin=0 -> out_valid exactly 8 cycles after accept; result=33'h0_0000_0003.
- a=32'hFFFF_FFFF, b=0, cin=1 (carry ripples through all 8 chunks) -> result=33'h1_0000_0000.
- a=32'hFFFF_FFFF, b=32'hFFFF_FFFF, cin=1 -> result=33'h1_FFFF_FFFF.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. result stays stable and in_ready=0 throughout. A new in_valid is ignored until the handshake, then accepted.
- Back-to-back: 100 random operand pairs, out_ready always 1 -> each result equals a+b+cin; accept spacing is exactly 10 cycles. Repeat with WIDTH=8, CHUNK=8.

Source files
------------

// File: rtl/chunked_add_sequencer_pkg.sv
// Shared types and helpers for the chunked add sequencer: FSM state encoding
// and the chunk-counter width rule.
package chunked_add_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // A single-chunk configuration still needs a 1-bit counter.
  function automatic int cnt_width(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/carry_lookahead_adder.sv
// N-bit carry-lookahead adder: every carry is a flat sum-of-products of the
// generate/propagate terms, so no carry ripples through earlier bit positions.
module carry_lookahead_adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N:0]   sum
);

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   carry;

  assign g        = a & b;
  assign p        = a ^ b;
  assign carry[0] = cin;

  for (genvar gi = 0; gi < N; gi++) begin : g_carry
    // terms[0] is the carry-in propagated through bits 0..gi; terms[gj+1] is
    // bit gj generating a carry that propagates through bits gj+1..gi.
    logic [gi+1:0] terms;
    assign terms[0] = cin & (&p[gi:0]);
    for (genvar gj = 0; gj <= gi; gj++) begin : g_term
      if (gj == gi) begin : g_own
        assign terms[gj+1] = g[gj];
      end else begin : g_prop
        assign terms[gj+1] = g[gj] & (&p[gi:gj+1]);
      end
    end
    assign carry[gi+1] = |terms;
  end

  assign sum = {carry[N], p ^ carry[N-1:0]};

endmodule

// File: rtl/chunked_add_sequencer.sv
// Multi-cycle wide adder: one CHUNK-bit carry-lookahead adder is stepped over
// the operands LSB chunk first, with the carry held in a register between cycles.
module chunked_add_sequencer
  import chunked_add_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   result,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = cnt_width(NCHUNK);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if ((WIDTH % CHUNK) != 0) begin : g_bad_width
    $error("chunked_add_sequencer: WIDTH must be a multiple of CHUNK");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   result_q, result_d;

  logic             clear;
  logic             step;
  logic [CHUNK:0]   cla_sum;
  logic [CHUNK-1:0] sum_chunk;
  logic             cout;

  carry_lookahead_adder #(
    .N(CHUNK)
  ) u_cla (
    .a  (a_q[CHUNK-1:0]),
    .b  (b_q[CHUNK-1:0]),
    .cin(carry_q),
    .sum(cla_sum)
  );

  assign sum_chunk = cla_sum[CHUNK-1:0];
  assign cout      = cla_sum[CHUNK];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    clear   = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          clear   = 1'b1;
        end
      end
      RUN: begin
        step    = 1'b1;
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Each result chunk only changes on the RUN cycle whose counter selects it.
  for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_result
    assign result_d[gi*CHUNK +: CHUNK] =
      clear                          ? '0 :
      (step && cnt_q == CW'(gi))     ? sum_chunk :
                                       result_q[gi*CHUNK +: CHUNK];
  end

  assign result_d[WIDTH] = clear                   ? 1'b0 :
                           (step && cnt_q == LAST) ? cout :
                                                     result_q[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;

endmodule
